mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU).
//  Round-robin arbitration; accepts one request, drives it to memory, waits for the response and returns it to the winner.
//  One transaction is outstanding at a time. A timeout turns a missing memory response into an error response.
//  Sits between the IFU/LSU and the memory, replacing their direct combinational fetch/ram paths.
// PARAMETERS
//  WIDTH    32   address/data width
//  TIMEOUT  255  max cycles in REQ+WAIT before an error response (>=1)
// PORTS
//  clk             in   1       clock, all state on posedge
//  rst             in   1       synchronous, active-high reset
//  ifu_req_valid   in   1       IFU read request
//  ifu_req_ready   out  1       IFU request accepted this cycle
//  ifu_addr        in   WIDTH   IFU read address
//  ifu_resp_valid  out  1       IFU response pulse
//  ifu_rdata       out  WIDTH   IFU read data
//  ifu_resp_err    out  1       IFU response is timeout error
//  lsu_req_valid   in   1       LSU request
//  lsu_req_ready   out  1       LSU request accepted this cycle
//  lsu_addr        in   WIDTH   LSU address
//  lsu_wen         in   1       1=write, 0=read
//  lsu_wdata       in   WIDTH   LSU write data
//  lsu_wmask       in   4       LSU byte strobes
//  lsu_resp_valid  out  1       LSU response pulse (reads and writes)
//  lsu_rdata       out  WIDTH   LSU read data (0 for writes)
//  lsu_resp_err    out  1       LSU response is timeout error
//  mem_req_valid   out  1       request to memory
//  mem_req_ready   in   1       memory accepts request
//  mem_addr/mem_wen/mem_wdata/mem_wmask  out  WIDTH/1/WIDTH/4  latched request fields
//  mem_resp_valid  in   1       memory response
//  mem_rdata       in   WIDTH   memory read data
// BEHAVIOUR
//  States: IDLE -> REQ -> WAIT -> RESP -> IDLE. Register last_grant (0=IFU, 1=LSU).
//  Reset: state=IDLE, last_grant=LSU (IFU wins first tie), counter=0; all outputs 0.
//  IDLE: x_req_ready is combinational and asserted only for the winner.
//   - One requester valid: that requester wins.
//   - Both valid: the requester that is not last_grant wins.
//   - On the handshake: latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and the owner; last_grant <= owner; -> REQ.
//  REQ: mem_req_valid=1, fields held stable from the latches.
//   - mem_req_ready & mem_resp_valid in the same cycle: capture rdata, -> RESP.
//   - mem_req_ready only: -> WAIT.
//  WAIT: mem_req_valid=0; mem_resp_valid: capture mem_rdata (0 if write), err=0, -> RESP.
//  Timeout:
//   - Counter clears on entering REQ and increments every cycle in REQ/WAIT.
//   - Counter reaches TIMEOUT with no completing event: rdata=0, err=1, -> RESP, mem_req_valid drops.
//   - A completing event in that same cycle takes precedence over the timeout.
//  RESP: owner's resp_valid=1 for exactly 1 cycle with rdata/err. The other master's resp outputs are 0. -> IDLE.
//  No request is accepted in RESP; next acceptance earliest the following IDLE cycle.
//  mem_resp_valid outside REQ/WAIT (incl. late responses after timeout): ignored.
//  Latency: accept at cycle N; mem_req_valid from N+1; min resp_valid at N+2 (memory answers in REQ); throughput <= 1 txn / 3 cycles.
//  Masters must hold valid+fields until ready; responses carry no backpressure (masters always accept).
//  rst mid-transaction: aborts to IDLE next cycle, no response issued, mem_req_valid=0.
// TESTING
//  IFU alone, addr=0x80000000, mem ready+resp in same cycle, rdata=0x00000413 -> ifu_resp_valid at N+2, rdata 0x00000413, err 0.
//  Both valid after reset -> IFU granted first; both held valid -> grants alternate IFU,LSU,IFU,LSU.
//  LSU write addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, mem_req_ready stalled 3 cycles -> mem fields stable; lsu_resp_valid, rdata 0.
//  TIMEOUT=4, mem never ready -> lsu_resp_err=1, rdata=0 at 4 cycles after REQ entry; late mem_resp_valid ignored.
//  rst asserted in WAIT -> state IDLE, no resp pulse; next ifu request served normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Purpose: bundles the IFU, LSU and memory-side signals of mem_bus_arbiter.
// Ports (all signals are members of the interface):
//   ifu_req_valid/ifu_req_ready/ifu_addr                  IFU request
//   ifu_resp_valid/ifu_rdata/ifu_resp_err                 IFU response
//   lsu_req_valid/lsu_req_ready/lsu_addr/lsu_wen/
//   lsu_wdata/lsu_wmask                                   LSU request
//   lsu_resp_valid/lsu_rdata/lsu_resp_err                 LSU response
//   mem_req_valid/mem_req_ready/mem_addr/mem_wen/
//   mem_wdata/mem_wmask/mem_resp_valid/mem_rdata          memory port
// Modports: slave = arbiter view, master = IFU/LSU/memory agents.
interface mem_bus_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned MASK_W = 4;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [WIDTH-1:0]  ifu_addr;
  logic              ifu_resp_valid;
  logic [WIDTH-1:0]  ifu_rdata;
  logic              ifu_resp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [WIDTH-1:0]  lsu_addr;
  logic              lsu_wen;
  logic [WIDTH-1:0]  lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [WIDTH-1:0]  lsu_rdata;
  logic              lsu_resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [WIDTH-1:0]  mem_addr;
  logic              mem_wen;
  logic [WIDTH-1:0]  mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [WIDTH-1:0]  mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Purpose: round-robin arbiter sharing one memory port between IFU and LSU,
//   one outstanding transaction, timeout converts a missing response into an
//   error response.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  mem_bus_arbiter_if.slave  IFU/LSU request+response, memory port
//   x_req_ready is combinational (IDLE winner); all other outputs registered.
module mem_bus_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic        OWN_IFU = 1'b0;
  localparam logic        OWN_LSU = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              ifu_resp_valid_q, ifu_resp_valid_d;
  logic              lsu_resp_valid_q, lsu_resp_valid_d;
  logic [WIDTH-1:0]  ifu_rdata_q, ifu_rdata_d;
  logic [WIDTH-1:0]  lsu_rdata_q, lsu_rdata_d;
  logic              ifu_resp_err_q, ifu_resp_err_d;
  logic              lsu_resp_err_q, lsu_resp_err_d;

  logic              ifu_win, lsu_win, timeout_hit;
  logic              ifu_ready_c, lsu_ready_c;
  logic [WIDTH-1:0]  resp_data;
  logic              resp_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Arbitration, next state, request latching and response formation
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    cnt_d        = cnt_q;
    resp_data    = '0;
    resp_err     = 1'b0;
    ifu_ready_c  = 1'b0;
    lsu_ready_c  = 1'b0;

    // On a tie the requester that did not win last time goes first
    ifu_win = bus.ifu_req_valid && (!bus.lsu_req_valid || (last_grant_q == OWN_LSU));
    lsu_win = bus.lsu_req_valid && (!bus.ifu_req_valid || (last_grant_q == OWN_IFU));
    // Counter value in the TIMEOUT-th cycle spent in REQ/WAIT
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    unique case (state_q)
      S_IDLE: begin
        ifu_ready_c = ifu_win && !rst;
        lsu_ready_c = lsu_win && !rst;
        if (ifu_ready_c) begin
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          addr_d       = bus.ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          cnt_d        = '0;
          state_d      = S_REQ;
        end else if (lsu_ready_c) begin
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          addr_d       = bus.lsu_addr;
          wen_d        = bus.lsu_wen;
          wdata_d      = bus.lsu_wdata;
          wmask_d      = bus.lsu_wmask;
          cnt_d        = '0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completing response beats a timeout in the same cycle
        if (bus.mem_req_ready && bus.mem_resp_valid) begin
          resp_data = wen_q ? '0 : bus.mem_rdata;
          state_d   = S_RESP;
        end else if (timeout_hit) begin
          resp_err = 1'b1;
          state_d  = S_RESP;
        end else if (bus.mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_resp_valid) begin
          resp_data = wen_q ? '0 : bus.mem_rdata;
          state_d   = S_RESP;
        end else if (timeout_hit) begin
          resp_err = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs follow the next state; only the owner sees a response
    mem_req_valid_d  = (state_d == S_REQ);
    ifu_resp_valid_d = (state_d == S_RESP) && (owner_q == OWN_IFU);
    lsu_resp_valid_d = (state_d == S_RESP) && (owner_q == OWN_LSU);
    ifu_rdata_d      = ifu_resp_valid_d ? resp_data : '0;
    lsu_rdata_d      = lsu_resp_valid_d ? resp_data : '0;
    ifu_resp_err_d   = ifu_resp_valid_d && resp_err;
    lsu_resp_err_d   = lsu_resp_valid_d && resp_err;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q          <= OWN_IFU;
      last_grant_q     <= OWN_LSU;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      cnt_q            <= '0;
      mem_req_valid_q  <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      lsu_rdata_q      <= '0;
      ifu_resp_err_q   <= 1'b0;
      lsu_resp_err_q   <= 1'b0;
    end else begin
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      addr_q           <= addr_d;
      wen_q            <= wen_d;
      wdata_q          <= wdata_d;
      wmask_q          <= wmask_d;
      cnt_q            <= cnt_d;
      mem_req_valid_q  <= mem_req_valid_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      ifu_rdata_q      <= ifu_rdata_d;
      lsu_rdata_q      <= lsu_rdata_d;
      ifu_resp_err_q   <= ifu_resp_err_d;
      lsu_resp_err_q   <= lsu_resp_err_d;
    end
  end

  assign bus.ifu_req_ready  = ifu_ready_c;
  assign bus.lsu_req_ready  = lsu_ready_c;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.ifu_resp_err   = ifu_resp_err_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.lsu_resp_err   = lsu_resp_err_q;
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter with TIMEOUT=4: directed transaction table,
// reset-in-WAIT sequence, then random transactions against a timing model.
module tb_mem_bus_arbiter;
  localparam int unsigned T = 4;

  typedef struct {
    bit          ifu_v;
    bit          lsu_v;
    logic [31:0] ifu_addr;
    logic [31:0] lsu_addr;
    bit          lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    int          rdy_dly;   // REQ cycle index at which mem_req_ready pulses
    int          resp_dly;  // cycles after ready until mem_resp_valid
    logic [31:0] mem_rdata;
    bit          exp_ifu_win;
    int          exp_lat;   // cycles from accept to resp_valid
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_bus_arbiter_if #(.WIDTH(32)) bus ();

  mem_bus_arbiter #(.WIDTH(32), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit iv, bit lv, logic [31:0] ia, logic [31:0] la, bit we,
                              logic [31:0] wd, logic [3:0] wm, int rd, int rs,
                              logic [31:0] md, bit ew, int el, logic [31:0] er, bit ee);
    vec_t v;
    v.ifu_v = iv; v.lsu_v = lv; v.ifu_addr = ia; v.lsu_addr = la; v.lsu_wen = we;
    v.lsu_wdata = wd; v.lsu_wmask = wm; v.rdy_dly = rd; v.resp_dly = rs; v.mem_rdata = md;
    v.exp_ifu_win = ew; v.exp_lat = el; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic clear_inputs();
    bus.ifu_req_valid  = 1'b0; bus.ifu_addr  = '0;
    bus.lsu_req_valid  = 1'b0; bus.lsu_addr  = '0; bus.lsu_wen = 1'b0;
    bus.lsu_wdata      = '0;   bus.lsu_wmask = '0;
    bus.mem_req_ready  = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
  endtask

  // Runs one transaction from an idle arbiter and checks grant, memory side and response
  task automatic do_txn(input vec_t v, input string nm);
    logic [31:0] e_addr, e_wdata;
    logic        e_wen;
    logic [3:0]  e_wmask;
    logic [31:0] r_data;
    logic        r_err;
    logic [31:0] first_addr;
    int          lat, pulses, req_cnt, exp_req;
    bit          other_bad, fields_ok, own_v, oth_v;
    e_addr  = v.exp_ifu_win ? v.ifu_addr : v.lsu_addr;
    e_wen   = v.exp_ifu_win ? 1'b0 : v.lsu_wen;
    e_wdata = v.exp_ifu_win ? 32'h0 : v.lsu_wdata;
    e_wmask = v.exp_ifu_win ? 4'h0 : v.lsu_wmask;
    exp_req = ((v.rdy_dly < int'(T)) ? v.rdy_dly : int'(T) - 1) + 1;
    lat = -1; pulses = 0; req_cnt = 0; other_bad = 1'b0; fields_ok = 1'b1;
    r_data = '0; r_err = 1'b0; first_addr = '0;

    @(negedge clk);
    clear_inputs();
    bus.ifu_req_valid = v.ifu_v; bus.ifu_addr = v.ifu_addr;
    bus.lsu_req_valid = v.lsu_v; bus.lsu_addr = v.lsu_addr; bus.lsu_wen = v.lsu_wen;
    bus.lsu_wdata = v.lsu_wdata; bus.lsu_wmask = v.lsu_wmask;
    #1;
    chk({nm, " ready"}, 64'({bus.ifu_req_ready, bus.lsu_req_ready}),
        64'({v.exp_ifu_win, !v.exp_ifu_win}));

    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      bus.ifu_req_valid  = 1'b0;
      bus.lsu_req_valid  = 1'b0;
      bus.mem_req_ready  = ((j - 1) == v.rdy_dly);
      bus.mem_resp_valid = ((j - 1) == v.rdy_dly + v.resp_dly);
      bus.mem_rdata      = v.mem_rdata;
      #1;
      if (j == 1) first_addr = bus.mem_addr;
      if (bus.mem_req_valid) begin
        req_cnt++;
        if (bus.mem_addr !== e_addr || bus.mem_wen !== e_wen ||
            bus.mem_wdata !== e_wdata || bus.mem_wmask !== e_wmask) fields_ok = 1'b0;
      end
      own_v = v.exp_ifu_win ? bus.ifu_resp_valid : bus.lsu_resp_valid;
      oth_v = v.exp_ifu_win ? bus.lsu_resp_valid : bus.ifu_resp_valid;
      if (own_v) begin
        pulses++;
        if (lat < 0) begin
          lat    = j;
          r_data = v.exp_ifu_win ? bus.ifu_rdata : bus.lsu_rdata;
          r_err  = v.exp_ifu_win ? bus.ifu_resp_err : bus.lsu_resp_err;
        end
      end
      if (oth_v || (v.exp_ifu_win ? (bus.lsu_rdata != 0 || bus.lsu_resp_err)
                                  : (bus.ifu_rdata != 0 || bus.ifu_resp_err))) other_bad = 1'b1;
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;

    chk({nm, " mem_addr"},  64'(first_addr), 64'(e_addr));
    chk({nm, " req_cycles"}, 64'(req_cnt), 64'(exp_req));
    chk({nm, " fields_stable"}, 64'(fields_ok), 64'(1));
    chk({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
    chk({nm, " rdata"}, 64'(r_data), 64'(v.exp_rdata));
    chk({nm, " err"}, 64'(r_err), 64'(v.exp_err));
    chk({nm, " pulses"}, 64'(pulses), 64'(1));
    chk({nm, " other_quiet"}, 64'(other_bad), 64'(0));
  endtask

  vec_t tbl[9];

  initial begin
    vec_t v;
    int   pulses;
    bit   m_last_lsu;
    int   done_idx;
    total = 0;
    bad   = 0;

    // {ifu_v, lsu_v, ifu_addr, lsu_addr, wen, wdata, wmask, rdy, resp, mem_rdata, win_ifu, lat, rdata, err}
    tbl[0] = mk(1, 1, 32'h8000_0000, 32'h8000_0100, 0, 0, 0, 0, 0, 32'h0000_0413, 1, 2, 32'h0000_0413, 0);
    tbl[1] = mk(1, 1, 32'h8000_0004, 32'h8000_0100, 0, 0, 0, 1, 1, 32'h1111_2222, 0, 4, 32'h1111_2222, 0);
    tbl[2] = mk(1, 1, 32'h0000_1000, 32'h8000_0200, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 1, 2, 32'hCAFE_F00D, 0);
    tbl[3] = mk(1, 1, 32'h0000_1004, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 3, 0, 32'h1234_5678, 0, 5, 32'h0, 0);
    tbl[4] = mk(0, 1, 32'h0, 32'h0000_0020, 0, 0, 0, 99, 0, 32'hFFFF_FFFF, 0, 5, 32'h0, 1);
    tbl[5] = mk(0, 1, 32'h0, 32'h0000_0024, 0, 0, 0, 0, 6, 32'hAAAA_5555, 0, 5, 32'h0, 1);
    tbl[6] = mk(1, 0, 32'h0000_2000, 32'h0, 0, 0, 0, 2, 1, 32'h0BAD_F00D, 1, 5, 32'h0BAD_F00D, 0);
    tbl[7] = mk(1, 0, 32'h0000_2004, 32'h0, 0, 0, 0, 3, 1, 32'h7777_7777, 1, 5, 32'h0, 1);
    tbl[8] = mk(0, 1, 32'h0, 32'h0000_0030, 1, 32'h0102_0304, 4'h3, 0, 2, 32'h5A5A_5A5A, 0, 4, 32'h0, 0);

    // Reset state
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst ready", 64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'(0));
    chk("rst mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("rst resp", 64'({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_err}), 64'(0));
    chk("rst rdata", {bus.ifu_rdata, bus.lsu_rdata}, 64'(0));
    chk("rst mem fields", 64'({bus.mem_addr, bus.mem_wen, bus.mem_wmask}) | 64'(bus.mem_wdata), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) do_txn(tbl[i], $sformatf("row%0d", i));

    // Reset while waiting for a memory response
    @(negedge clk);
    clear_inputs();
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h0000_0044;
    #1;
    chk("rstwait accept", 64'(bus.ifu_req_ready), 64'(1));
    @(negedge clk);
    bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    #1;
    chk("rstwait req", 64'(bus.mem_req_valid), 64'(1));
    @(negedge clk);
    bus.mem_req_ready = 1'b0; rst = 1'b1;
    #1;
    chk("rstwait in_wait", 64'(bus.mem_req_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h9999_9999;
    #1;
    chk("rstwait after_rst", 64'({bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid}), 64'(0));
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      #1;
      if (bus.ifu_resp_valid || bus.lsu_resp_valid || bus.mem_req_valid) pulses++;
    end
    chk("rstwait no_resp", 64'(pulses), 64'(0));
    // last_grant back to LSU after reset, so IFU wins the tie
    do_txn(mk(1, 1, 32'h0000_0050, 32'h0000_0060, 0, 0, 0, 0, 0, 32'h0000_0413, 1, 2, 32'h0000_0413, 0),
           "post_rst");

    // Random transactions against a model of grant order and completion time
    m_last_lsu = 1'b0;
    for (int n = 0; n < 40; n++) begin
      v.ifu_v     = 1'($urandom_range(0, 1));
      v.lsu_v     = 1'($urandom_range(0, 1));
      if (!v.ifu_v && !v.lsu_v) begin
        if ($urandom_range(0, 1) == 0) v.ifu_v = 1'b1;
        else                           v.lsu_v = 1'b1;
      end
      v.ifu_addr  = $urandom;
      v.lsu_addr  = $urandom;
      v.lsu_wen   = 1'($urandom_range(0, 1));
      v.lsu_wdata = $urandom;
      v.lsu_wmask = 4'($urandom);
      v.rdy_dly   = ($urandom_range(0, 5) == 5) ? 99 : int'($urandom_range(0, 4));
      v.resp_dly  = int'($urandom_range(0, 4));
      v.mem_rdata = $urandom;

      v.exp_ifu_win = v.ifu_v && (!v.lsu_v || m_last_lsu);
      m_last_lsu    = !v.exp_ifu_win;
      done_idx      = v.rdy_dly + v.resp_dly;
      if (done_idx <= int'(T) - 1) begin
        v.exp_lat   = 2 + done_idx;
        v.exp_err   = 1'b0;
        v.exp_rdata = (!v.exp_ifu_win && v.lsu_wen) ? 32'h0 : v.mem_rdata;
      end else begin
        v.exp_lat   = int'(T) + 1;
        v.exp_err   = 1'b1;
        v.exp_rdata = 32'h0;
      end
      do_txn(v, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
